// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_ADDR_W / XLEN : register address and data widths
//   wb_arb_state_t    : writeback arbiter states (sweep, then normal arbitration)
//   wb_req_t          : one writeback request (destination + data)
//   is_x0()           : true for the hardwired-zero register address
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    WB_INIT = 1'b0,
    WB_RUN  = 1'b1
  } wb_arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register
// file write port.
//   reqN_valid/addr/data : requester N write request (requester drives)
//   reqN_ready           : requester N accepted this cycle (arbiter drives)
//   init_done            : initialisation sweep finished
//   wr_ena/addr/data     : registered register-file write port
// Handshake: a write transfers in the cycle where valid && ready are both
// high. Once valid is raised, the requester holds valid, addr and data
// stable until it sees ready; ready may depend combinationally on valid.
// modport slave  : the arbiter side
// modport master : the requester / register-file side
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [XLEN-1:0]       req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [XLEN-1:0]       req1_data;

  logic                  init_done;
  logic                  wr_ena;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output init_done, wr_ena, wr_addr, wr_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  init_done, wr_ena, wr_addr, wr_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req[1:0]   : request lines
//   i_accept     : grants may be issued this cycle (0 forces no grant)
//   o_grant[1:0] : one-hot grant (combinational), zero when nothing granted
//   o_last_grant : index of the most recently granted requester
// A lone requester always wins; on a tie the requester that did not win
// last time is granted. Reset leaves last_grant at 1 so requester 0 wins
// the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_last_grant
);

  logic       r_last_grant;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_accept) begin
      case (i_req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (|w_grant) begin
      r_last_grant <= w_grant[1];
    end
  end

  assign o_grant      = w_grant;
  assign o_last_grant = r_last_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register file's single write port.
// After reset it sweeps INIT_VALUE into x01..x31 (the register file has no
// reset), then round-robin arbitrates the ALU (req0) and load (req1)
// writeback requesters onto the port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : requester handshakes, init_done, registered wr_* port
//   o_dbg_state       : current arbiter state
//   o_dbg_last_grant  : requester granted most recently
// Parameters:
//   INIT_ENABLE : 1 = run the sweep after reset, 0 = go straight to RUN
//   INIT_VALUE  : value written to x01..x31 by the sweep
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter bit              INIT_ENABLE = 1'b1,
  parameter logic [XLEN-1:0] INIT_VALUE  = 32'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus,
  output wb_arb_state_t       o_dbg_state,
  output logic                o_dbg_last_grant
);

  wb_arb_state_t         r_state;
  logic [REG_ADDR_W-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_wr_ena;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;

  logic                  w_run;
  logic [1:0]            w_req;
  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_last_grant;
  wb_req_t               w_sel;

  assign w_run = (r_state == WB_RUN);
  assign w_req = {bus.req1_valid, bus.req0_valid};

  // Arbitration is only enabled in RUN, so ready stays low during the sweep
  // and a request raised early simply waits with valid held.
  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (w_req),
    .i_accept     (w_run),
    .o_grant      (w_grant),
    .o_last_grant (w_last_grant)
  );

  assign w_accept       = |w_grant;
  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  always_comb begin
    w_sel.addr = bus.req0_addr;
    w_sel.data = bus.req0_data;
    if (w_grant[1]) begin
      w_sel.addr = bus.req1_addr;
      w_sel.data = bus.req1_data;
    end
  end

  // The sweep counter starts at 1 and wraps to 0 after writing x31; the
  // wrapped value marks the end of the sweep, so x00 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WB_INIT;
      r_init_cnt  <= REG_ADDR_W'(1);
      r_init_done <= 1'b0;
      r_wr_ena    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        WB_INIT: begin
          if (!INIT_ENABLE || (r_init_cnt == '0)) begin
            r_wr_ena    <= 1'b0;
            r_init_done <= 1'b1;
            r_state     <= WB_RUN;
          end else begin
            r_wr_ena   <= 1'b1;
            r_wr_addr  <= r_init_cnt;
            r_wr_data  <= INIT_VALUE;
            r_init_cnt <= r_init_cnt + REG_ADDR_W'(1);
          end
        end
        WB_RUN: begin
          // A write to x0 is accepted but never reaches the port; address
          // and data hold whenever no write is issued.
          if (w_accept && !is_x0(w_sel.addr)) begin
            r_wr_ena  <= 1'b1;
            r_wr_addr <= w_sel.addr;
            r_wr_data <= w_sel.data;
          end else begin
            r_wr_ena  <= 1'b0;
          end
        end
        default: begin
          r_state  <= WB_INIT;
          r_wr_ena <= 1'b0;
        end
      endcase
    end
  end

  assign bus.init_done = r_init_done;
  assign bus.wr_ena    = r_wr_ena;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = w_last_grant;

endmodule
